// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: control-bundle field layout
// and the occupancy state encoding.
package pipe_pkg;

    localparam int PIPE_CTRL_W = 11;

    // Control bundle field offsets; bits above ALUOP are reserved.
    localparam int CTRL_WMEM     = 0;
    localparam int CTRL_RMEM     = 1;
    localparam int CTRL_WREG     = 2;
    localparam int CTRL_WPC      = 3;
    localparam int CTRL_JMP_LO   = 4;
    localparam int CTRL_JMP_W    = 2;
    localparam int CTRL_ALUOP_LO = 6;
    localparam int CTRL_ALUOP_W  = 3;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a plain register with load enable and synchronous
// active-low clear.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: main entry plus one skid entry, with
// registered in_ready, flush and squashing of side-effect controls on bubbles.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W           = 32,
    parameter int                REG_W            = 4,
    parameter int                NUM_SRC          = 2,
    parameter int                CTRL_W           = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] SIDE_EFFECT_MASK = 11'h7FF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [NUM_SRC*DATA_W-1:0] in_data,
    input  logic [NUM_SRC*REG_W-1:0]  in_src,
    input  logic [REG_W-1:0]          in_dest,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [NUM_SRC*DATA_W-1:0] out_data,
    output logic [NUM_SRC*REG_W-1:0]  out_src,
    output logic [REG_W-1:0]          out_dest,
    output logic [1:0]                occupancy
);

    localparam int ENTRY_W = CTRL_W + NUM_SRC*DATA_W + NUM_SRC*REG_W + REG_W;

    occ_t               occ_reg, occ_next;
    logic               in_ready_reg, in_ready_next;
    logic               main_load, skid_load, main_from_skid;
    logic [ENTRY_W-1:0] in_entry, main_d, main_q, skid_q;
    logic [CTRL_W-1:0]  main_ctrl;
    logic               in_xfer, out_xfer;

    assign in_entry = {in_ctrl, in_data, in_src, in_dest};
    assign in_xfer  = in_valid & in_ready_reg;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_reg      <= OCC_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            occ_reg      <= occ_next;
            in_ready_reg <= in_ready_next;
        end
    end

    always_comb begin
        occ_next       = occ_reg;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            occ_next = OCC_EMPTY;
        end else begin
            case (occ_reg)
                OCC_EMPTY: begin
                    if (in_xfer) begin
                        occ_next  = OCC_ONE;
                        main_load = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        occ_next  = OCC_TWO;
                        skid_load = 1'b1;
                    end else if (!in_xfer && out_xfer) begin
                        occ_next = OCC_EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (out_xfer) begin
                        occ_next       = OCC_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: occ_next = OCC_EMPTY;
            endcase
        end
        // Ready is a register, so decide it from where we are going, not where we are.
        in_ready_next = (occ_next != OCC_TWO);
    end

    assign main_d = main_from_skid ? skid_q : in_entry;

    pipe_entry_reg #(.W(ENTRY_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_entry_reg #(.W(ENTRY_W)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid_q)
    );

    assign {main_ctrl, out_data, out_src, out_dest} = main_q;

    assign out_valid = (occ_reg != OCC_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl : (main_ctrl & ~SIDE_EFFECT_MASK);
    assign in_ready  = in_ready_reg;
    assign occupancy = occ_reg;

endmodule
